// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t : FSM state encoding (IDLE / RUN / DONE)
//   clog2() : constant function giving the bit-counter width for N operand bits
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to index N bits (0 .. N-1); at least 1 for N >= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mul_shift_stage.sv
// One combinational partial-product step of the shift-add multiplier.
// Ports:
//   acc_i [2N-1:0] : running accumulator
//   a_i   [N-1:0]  : latched multiplicand
//   idx_i [CW-1:0] : multiplier bit index being processed
//   bit_i          : value of b[idx_i]
//   sub_i          : subtract the partial product instead of adding it
//   acc_o [2N-1:0] : accumulator after this step
module mul_shift_stage
  import mul_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned CW     = clog2(N)
) (
  input  logic [2*N-1:0] acc_i,
  input  logic [N-1:0]   a_i,
  input  logic [CW-1:0]  idx_i,
  input  logic           bit_i,
  input  logic           sub_i,
  output logic [2*N-1:0] acc_o
);

  logic           ext_bit;
  logic [2*N-1:0] a_ext;
  logic [2*N-1:0] pp;

  always_comb begin
    ext_bit = (SIGNED != 0) ? a_i[N-1] : 1'b0;
    a_ext   = {{N{ext_bit}}, a_i};
    pp      = a_ext << idx_i;
    acc_o   = acc_i;
    if (bit_i) begin
      acc_o = sub_i ? (acc_i - pp) : (acc_i + pp);
    end
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-add multiplier, one multiplier bit per clock, LSB first.
// In signed mode the MSB partial product is subtracted (two's-complement weight).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b  [N-1:0]       : multiplicand, multiplier
//   out_valid/out_ready : result handshake (p held in DONE until accepted)
//   p     [2N-1:0]      : product, kept after the handshake
//   busy                : state is not IDLE
// Build option: define MUL_EARLY_TERM_EN to finish RUN as soon as the
// remaining multiplier bits are all zero (latency max(1, msb index + 1)).
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned SIGNED = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int unsigned   CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] p_q;
  logic           out_valid_q;

  logic [N-1:0]   b_rem;
  logic           cur_bit;
  logic           sub_step;
  logic           last_step;

  always_comb begin
    b_rem    = b_q >> cnt_q;
    cur_bit  = b_rem[0];
    sub_step = (SIGNED != 0) && (cnt_q == LAST);
`ifdef MUL_EARLY_TERM_EN
    // Done once no set bit remains above the current one.
    last_step = (b_rem[N-1:1] == '0);
`else
    last_step = (cnt_q == LAST);
`endif
  end

  mul_shift_stage #(
    .N      (N),
    .SIGNED (SIGNED),
    .CW     (CW)
  ) u_stage (
    .acc_i (acc_q),
    .a_i   (a_q),
    .idx_i (cnt_q),
    .bit_i (cur_bit),
    .sub_i (sub_step),
    .acc_o (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            p_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule
